camera_sccb_config: RTL

//   SCCB (OV7670-class) register-write sequencer. It is the stage directly downstream of the camera power-up start pulse.
//   - An active-low start strobe launches a walk through an internal ROM of {reg_addr, reg_data} pairs.
//   - Each pair is issued as a 3-phase SCCB write (device ID, sub-address, data). SIOD is driven open-drain.
//   - Reports busy/done/error to the capture pipeline, which must not sample pixels before o_done.

---
 rtl/camera_sccb_config.sv | 280 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/camera_sccb_config.sv
// SCCB register-write sequencer: walks an internal {reg_addr, reg_data} ROM and issues 3-phase writes.
// Optional NACK detection and per-entry retry is built when SCCB_ACK_CHECK_EN is defined.
module camera_sccb_config #(
  parameter logic [7:0]  DEV_ADDR       = 8'h42,
  parameter int unsigned QUARTER_CYCLES = 125,
  parameter int unsigned WAIT_UNIT      = 50000,
  parameter int unsigned ROM_DEPTH      = 64,
  parameter int unsigned RETRY_MAX      = 3,
  localparam int unsigned IW            = $clog2(ROM_DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start_n,
  input  logic          i_siod,
  output logic          o_sioc,
  output logic          o_siod_oe,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_error,
  output logic [IW-1:0] o_index
);

  localparam int unsigned QW = $clog2(QUARTER_CYCLES + 1);
  localparam int unsigned WW = $clog2(255 * WAIT_UNIT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_START, S_BIT, S_STOP, S_GAP, S_WAIT, S_DONE, S_ERROR
  } state_t;

  state_t          state, state_n;
  logic [QW-1:0]   qdiv, qdiv_n;
  logic [1:0]      q, q_n;
  logic [4:0]      bit_cnt, bit_n;
  logic [26:0]     frame, frame_n;
  logic [WW-1:0]   wcnt, wcnt_n;
  logic [IW-1:0]   index, index_n;
  logic            busy, busy_n, done, done_n, error, error_n;
  logic            sioc, siod_oe, start_q;
  logic            tick, trigger, ack_slot;
  logic [15:0]     entry;
  logic [1:0]      levels_n;

`ifdef SCCB_ACK_CHECK_EN
  localparam int unsigned RW = $clog2(RETRY_MAX + 1);
  logic            nack, nack_n;
  logic [RW-1:0]   retry, retry_n;
`else
  logic            unused_siod;
  assign unused_siod = i_siod;
`endif

  // The last slot is always forced to the end marker so the index can never wrap.
  function automatic logic [15:0] rom_entry(input logic [IW-1:0] idx);
    logic [15:0] e;
    if (32'(idx) == ROM_DEPTH - 1) return 16'hFFFF;
    case (32'(idx))
      0:  e = 16'h1280;  // COM7 soft reset
      1:  e = 16'hFE0A;  // let the sensor settle after reset
      2:  e = 16'h1204;
      3:  e = 16'h1101;
      4:  e = 16'h0C00;
      5:  e = 16'h3E00;
      6:  e = 16'h40D0;
      7:  e = 16'h3A04;
      8:  e = 16'h1418;
      9:  e = 16'h4FB3;
      10: e = 16'h50B3;
      11: e = 16'h5100;
      12: e = 16'h523D;
      13: e = 16'h53A7;
      14: e = 16'h54E4;
      15: e = 16'h589E;
      16: e = 16'h3DC0;
      17: e = 16'h1714;
      18: e = 16'h1802;
      19: e = 16'h3280;
      20: e = 16'h1903;
      21: e = 16'h1A7B;
      22: e = 16'h030A;
      23: e = 16'h0F41;
      24: e = 16'h1E00;
      25: e = 16'h330B;
      26: e = 16'h3C78;
      27: e = 16'h6900;
      28: e = 16'h7400;
      29: e = 16'hB084;
      30: e = 16'hB10C;
      31: e = 16'hB20E;
      32: e = 16'hB380;
      default: e = 16'hFFFF;
    endcase
    return e;
  endfunction

  // {sioc, siod_oe} for a given position in the write; frame bit = 1 means release.
  function automatic logic [1:0] bus_levels(input state_t st, input logic [1:0] qq,
                                            input logic [4:0] bb, input logic [26:0] fr);
    logic [1:0] lv;
    lv = 2'b10;
    case (st)
      S_START: lv = 2'b11;
      S_BIT:   lv = {qq[1], ~fr[5'd26 - bb]};
      S_STOP:  lv = (qq == 2'd0) ? 2'b01 : ((qq == 2'd1) ? 2'b11 : 2'b10);
      default: lv = 2'b10;
    endcase
    return lv;
  endfunction

  assign tick     = (qdiv == QW'(QUARTER_CYCLES - 1));
  assign trigger  = start_q & ~i_start_n;
  assign ack_slot = (bit_cnt == 5'd8) || (bit_cnt == 5'd17) || (bit_cnt == 5'd26);
  assign entry    = rom_entry(index);

  always_comb begin
    state_n = state;
    qdiv_n  = '0;
    q_n     = q;
    bit_n   = bit_cnt;
    frame_n = frame;
    wcnt_n  = wcnt;
    index_n = index;
    busy_n  = busy;
    done_n  = done;
    error_n = error;
`ifdef SCCB_ACK_CHECK_EN
    nack_n  = nack;
    retry_n = retry;
`endif
    if (state inside {S_START, S_BIT, S_STOP, S_GAP}) begin
      qdiv_n = tick ? '0 : qdiv + 1'b1;
      if (tick) q_n = q + 2'd1;
    end

    if (trigger && (state inside {S_IDLE, S_DONE, S_ERROR})) begin
      state_n = S_LOAD;
      index_n = '0;
      busy_n  = 1'b1;
      done_n  = 1'b0;
      error_n = 1'b0;
`ifdef SCCB_ACK_CHECK_EN
      retry_n = '0;
`endif
    end else begin
      case (state)
        S_LOAD: begin
          if (entry == 16'hFFFF) begin
            state_n = S_DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else if (entry[15:8] == 8'hFE) begin
            if (entry[7:0] == 8'd0) begin
              index_n = index + 1'b1;
            end else begin
              state_n = S_WAIT;
              wcnt_n  = WW'(32'(entry[7:0]) * WAIT_UNIT - 32'd1);
            end
          end else begin
            frame_n = {DEV_ADDR, 1'b1, entry[15:8], 1'b1, entry[7:0], 1'b1};
            state_n = S_START;
            q_n     = '0;
            bit_n   = '0;
`ifdef SCCB_ACK_CHECK_EN
            nack_n  = 1'b0;
`endif
          end
        end
        S_WAIT: begin
          if (wcnt == '0) begin
            state_n = S_LOAD;
            index_n = index + 1'b1;
          end else begin
            wcnt_n = wcnt - 1'b1;
          end
        end
        S_START: begin
          if (tick && q == 2'd1) begin
            state_n = S_BIT;
            q_n     = '0;
          end
        end
        S_BIT: begin
          if (tick) begin
`ifdef SCCB_ACK_CHECK_EN
            if (q == 2'd2 && ack_slot) nack_n = i_siod;
            if (q == 2'd3) begin
              if (bit_cnt == 5'd26 || (ack_slot && nack)) state_n = S_STOP;
              else bit_n = bit_cnt + 5'd1;
            end
`else
            if (q == 2'd3) begin
              if (bit_cnt == 5'd26) state_n = S_STOP;
              else bit_n = bit_cnt + 5'd1;
            end
`endif
          end
        end
        S_STOP: begin
          if (tick && q == 2'd3) state_n = S_GAP;
        end
        S_GAP: begin
          if (tick && q == 2'd3) begin
            state_n = S_LOAD;
`ifdef SCCB_ACK_CHECK_EN
            // A NACKed entry is reissued from LOAD without advancing the index.
            if (nack) begin
              if (retry == RW'(RETRY_MAX)) begin
                state_n = S_ERROR;
                busy_n  = 1'b0;
                error_n = 1'b1;
              end else begin
                retry_n = retry + 1'b1;
              end
            end else begin
              index_n = index + 1'b1;
              retry_n = '0;
            end
`else
            index_n = index + 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign levels_n = bus_levels(state_n, q_n, bit_n, frame_n);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state   <= S_IDLE;
      qdiv    <= '0;
      q       <= '0;
      bit_cnt <= '0;
      frame   <= '1;
      wcnt    <= '0;
      index   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
      sioc    <= 1'b1;
      siod_oe <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state   <= state_n;
      qdiv    <= qdiv_n;
      q       <= q_n;
      bit_cnt <= bit_n;
      frame   <= frame_n;
      wcnt    <= wcnt_n;
      index   <= index_n;
      busy    <= busy_n;
      done    <= done_n;
      error   <= error_n;
      sioc    <= levels_n[1];
      siod_oe <= levels_n[0];
      start_q <= i_start_n;
    end
  end

`ifdef SCCB_ACK_CHECK_EN
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      nack  <= 1'b0;
      retry <= '0;
    end else begin
      nack  <= nack_n;
      retry <= retry_n;
    end
  end
`endif

  assign o_sioc    = sioc;
  assign o_siod_oe = siod_oe;
  assign o_busy    = busy;
  assign o_done    = done;
  assign o_error   = error;
  assign o_index   = index;

endmodule
